// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The optional branch target buffer is enabled by defining IF_BTB_EN.
package if_fetch_pkg;

    // Bus widths of the fetch datapath
    typedef logic [31:0] inst_addr_t;   // InstAddrBus
    typedef logic [31:0] inst_t;        // InstBus
    typedef logic [1:0]  stall_t;       // StallBus

    // Bit positions inside the global stall vector
    localparam int STALL_PC   = 0;
    localparam int STALL_IFID = 1;

    localparam inst_addr_t ZERO_WORD = 32'h0000_0000;

    // Default BTB geometry: 16 entries indexed by pc[5:2], tag from pc[17:6]
    localparam int BTB_IDX_W_DEF = 4;
    localparam int BTB_TAG_W_DEF = 12;

    // Fetch controller states
    typedef enum logic [1:0] {
        IfIdle = 2'd0,
        IfWait = 2'd1,
        IfHold = 2'd2
    } if_state_e;

    // Sequential next PC, 32-bit wrapping
    function automatic inst_addr_t pc_plus4(input inst_addr_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Instruction read bus between the fetch stage (master) and the memory
// controller (slave).
//
// Handshake: the master raises mem_req with a stable mem_addr and keeps both
// unchanged until the slave answers with a one-cycle mem_done pulse carrying
// mem_inst. A request is never withdrawn; the master drops mem_req on the
// edge that samples mem_done. mem_inst is only meaningful while mem_done=1.
interface if_fetch_if;
    import if_fetch_pkg::*;

    logic       mem_req;
    inst_addr_t mem_addr;
    logic       mem_done;
    inst_t      mem_inst;

    modport master (output mem_req, output mem_addr, input mem_done, input mem_inst);
    modport slave  (input mem_req, input mem_addr, output mem_done, output mem_inst);

endinterface

// File: rtl/if_fetch_btb.sv
// Direct-mapped branch target buffer (if_btb) for the fetch stage.
// Only compiled when IF_BTB_EN is defined. Lookup is combinational and sees
// the table contents from before any update issued in the same cycle.
`ifdef IF_BTB_EN
module if_fetch_btb
    import if_fetch_pkg::*;
#(
    parameter int IDX_W = BTB_IDX_W_DEF,
    parameter int TAG_W = BTB_TAG_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    input  inst_addr_t lookup_pc,
    output inst_addr_t lookup_pred,
    input  logic       upd_en,
    input  inst_addr_t upd_pc,
    input  inst_addr_t upd_target,
    input  logic       upd_taken
);

    localparam int N = 1 << IDX_W;

    logic [N-1:0]     valid;
    logic [TAG_W-1:0] tag_mem [N];
    inst_addr_t       tgt_mem [N];

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit;

    // Word-aligned PCs: index starts above the byte offset, tag above the index
    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

    // Byte offset and high PC bits take no part in indexing or tagging
    wire unused_btb = ^{lookup_pc, upd_pc};

    // Valid bits: set on a taken update, dropped on a not-taken update that hits
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (rdy && upd_en) begin
            if (upd_taken) begin
                valid[up_idx] <= 1'b1;
            end else if (valid[up_idx] && (tag_mem[up_idx] == up_tag)) begin
                valid[up_idx] <= 1'b0;
            end
        end
    end

    // Tag and target storage; contents are qualified by the valid bits
    always_ff @(posedge clk) begin
        if (rdy && upd_en && upd_taken) begin
            tag_mem[up_idx] <= up_tag;
            tgt_mem[up_idx] <= upd_target;
        end
    end

    // Prediction: stored target on a hit, otherwise fall through
    always_comb begin
        lk_hit      = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);
        lookup_pred = lk_hit ? tgt_mem[lk_idx] : pc_plus4(lookup_pc);
    end

endmodule
`endif

// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the PC, reads one instruction at a time from
// the memory controller, predicts the next PC and holds the fetched
// instruction on the IF side of the IF/ID register until it is taken.
// Define IF_BTB_EN to predict with a branch target buffer; otherwise the
// prediction is always PC+4 and the upd_* inputs are ignored.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int BTB_IDX_W = BTB_IDX_W_DEF,
    parameter int BTB_TAG_W = BTB_TAG_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    input  stall_t     stall,
    input  logic       br,
    input  inst_addr_t br_target,
    input  logic       upd_en,
    input  inst_addr_t upd_pc,
    input  inst_addr_t upd_target,
    input  logic       upd_taken,
    if_fetch_if.master mbus,
    output inst_addr_t if_pc,
    output inst_addr_t if_npc,
    output inst_addr_t if_pred,
    output inst_t      if_inst,
    output logic       stallreq_if,
    output if_state_e  dbg_state
);

    if_state_e  state, state_n;
    inst_addr_t pc, pc_n;
    logic       kill, kill_n;       // in-flight read must be discarded
    logic       req_q, req_n;
    inst_addr_t addr_q, addr_n;
    inst_addr_t pc_o_n, npc_o_n, pred_o_n;
    inst_t      inst_o_n;
    inst_addr_t pred;               // predicted successor of pc

`ifdef IF_BTB_EN
    if_fetch_btb #(
        .IDX_W (BTB_IDX_W),
        .TAG_W (BTB_TAG_W)
    ) u_btb (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .lookup_pc   (pc),
        .lookup_pred (pred),
        .upd_en      (upd_en),
        .upd_pc      (upd_pc),
        .upd_target  (upd_target),
        .upd_taken   (upd_taken)
    );
`else
    assign pred = pc_plus4(pc);

    // Without a BTB the resolved-branch feedback and its geometry are unused
    wire unused_upd = ^{upd_en, upd_pc, upd_target, upd_taken};
    localparam int unused_btb_geom = BTB_IDX_W + BTB_TAG_W;
`endif

    assign mbus.mem_req  = req_q;
    assign mbus.mem_addr = addr_q;
    assign stallreq_if   = (state != IfHold);
    assign dbg_state     = state;

    // Next-state and next-output logic; a redirect overrides any stall
    always_comb begin
        state_n  = state;
        pc_n     = pc;
        kill_n   = kill;
        req_n    = req_q;
        addr_n   = addr_q;
        pc_o_n   = if_pc;
        npc_o_n  = if_npc;
        pred_o_n = if_pred;
        inst_o_n = if_inst;

        if (br) begin
            pc_n     = br_target;
            pc_o_n   = ZERO_WORD;
            npc_o_n  = ZERO_WORD;
            pred_o_n = ZERO_WORD;
            inst_o_n = ZERO_WORD;
        end

        case (state)
            IfIdle: begin
                if (!br && !stall[STALL_PC]) begin
                    req_n   = 1'b1;
                    addr_n  = pc;
                    state_n = IfWait;
                end
            end
            IfWait: begin
                if (mbus.mem_done) begin
                    // Read completes: keep it only if nothing redirected us
                    req_n   = 1'b0;
                    kill_n  = 1'b0;
                    state_n = IfIdle;
                    if (!br && !kill) begin
                        pc_o_n   = pc;
                        npc_o_n  = pc_plus4(pc);
                        pred_o_n = pred;
                        inst_o_n = mbus.mem_inst;
                        state_n  = IfHold;
                    end
                end else if (br) begin
                    // The read cannot be aborted; drop its data when it lands
                    kill_n = 1'b1;
                end
            end
            IfHold: begin
                if (br) begin
                    state_n = IfIdle;
                end else if (!stall[STALL_IFID]) begin
                    pc_n    = if_pred;
                    state_n = IfIdle;
                end
            end
            default: begin
                state_n = IfIdle;
            end
        endcase
    end

    // State and output registers; rdy low freezes everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IfIdle;
            pc      <= ZERO_WORD;
            kill    <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= ZERO_WORD;
            if_pc   <= ZERO_WORD;
            if_npc  <= ZERO_WORD;
            if_pred <= ZERO_WORD;
            if_inst <= ZERO_WORD;
        end else if (rdy) begin
            state   <= state_n;
            pc      <= pc_n;
            kill    <= kill_n;
            req_q   <= req_n;
            addr_q  <= addr_n;
            if_pc   <= pc_o_n;
            if_npc  <= npc_o_n;
            if_pred <= pred_o_n;
            if_inst <= inst_o_n;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: a memory responder answers each request
// after a fixed latency, directed stimulus pushes expected request addresses
// and expected presentations, and two monitors pop and compare them.
module tb_if_fetch;
    import if_fetch_pkg::*;

    localparam int MEM_LAT = 3;
    localparam int BUDGET  = 60;

    logic       clk;
    logic       rst;
    logic       rdy;
    stall_t     stall;
    logic       br;
    inst_addr_t br_target;
    logic       upd_en;
    inst_addr_t upd_pc;
    inst_addr_t upd_target;
    logic       upd_taken;
    inst_addr_t if_pc, if_npc, if_pred;
    inst_t      if_inst;
    logic       stallreq_if;
    if_state_e  dbg_state;

    if_fetch_if mbus();

    if_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .stall       (stall),
        .br          (br),
        .br_target   (br_target),
        .upd_en      (upd_en),
        .upd_pc      (upd_pc),
        .upd_target  (upd_target),
        .upd_taken   (upd_taken),
        .mbus        (mbus),
        .if_pc       (if_pc),
        .if_npc      (if_npc),
        .if_pred     (if_pred),
        .if_inst     (if_inst),
        .stallreq_if (stallreq_if),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [31:0]  exp_addr_q[$];
    logic [127:0] exp_pres_q[$];   // {pc, npc, inst, pred}

    function automatic inst_t inst_for(input inst_addr_t a);
        return {a[19:0], 12'h013};
    endfunction

    function automatic logic [127:0] pres(input inst_addr_t pc, input inst_addr_t npc,
                                          input inst_addr_t pred);
        return {pc, npc, inst_for(pc), pred};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: event not seen within %0d cycles", name, BUDGET);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_present(input string name);
        int k;
        k = 0;
        while (stallreq_if !== 1'b0 && k < BUDGET) begin
            tick();
            k++;
        end
        if (k >= BUDGET) timeout(name);
    endtask

    task automatic wait_req(input string name);
        int k;
        k = 0;
        while (mbus.mem_req !== 1'b1 && k < BUDGET) begin
            tick();
            k++;
        end
        if (k >= BUDGET) timeout(name);
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (mbus.mem_done !== 1'b1 && k < BUDGET) begin
            tick();
            k++;
        end
        if (k >= BUDGET) timeout(name);
    endtask

    // ---------------- memory responder ----------------
    initial begin
        int cnt;
        cnt = 0;
        mbus.mem_done = 1'b0;
        mbus.mem_inst = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                cnt = 0;
                mbus.mem_done = 1'b0;
                mbus.mem_inst = 32'hDEAD_BEEF;
            end else if (mbus.mem_done) begin
                mbus.mem_done = 1'b0;
                mbus.mem_inst = 32'hDEAD_BEEF;
            end else if (mbus.mem_req) begin
                cnt++;
                if (cnt == MEM_LAT) begin
                    mbus.mem_done = 1'b1;
                    mbus.mem_inst = inst_for(mbus.mem_addr);
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // ---------------- monitors ----------------
    initial begin
        logic prev_req;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (mbus.mem_req === 1'b1 && !prev_req) begin
                if (exp_addr_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL req_addr: got request to %h, required none", mbus.mem_addr);
                end else begin
                    check("req_addr", mbus.mem_addr, exp_addr_q.pop_front());
                end
            end
            prev_req = (mbus.mem_req === 1'b1);
        end
    end

    initial begin
        logic prev_sr;
        logic [127:0] e;
        prev_sr = 1'b1;
        forever begin
            @(negedge clk);
            if (stallreq_if === 1'b0 && prev_sr) begin
                if (exp_pres_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL present: got if_pc %h, required no presentation", if_pc);
                end else begin
                    e = exp_pres_q.pop_front();
                    check("if_pc",   if_pc,   e[127:96]);
                    check("if_npc",  if_npc,  e[95:64]);
                    check("if_inst", if_inst, e[63:32]);
                    check("if_pred", if_pred, e[31:0]);
                end
            end
            prev_sr = (stallreq_if !== 1'b0);
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1; rdy = 1'b1; stall = 2'b00; br = 1'b0; br_target = '0;
        upd_en = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0;
        repeat (3) tick();

        // reset values
        check("rst_mem_req",  {31'b0, mbus.mem_req}, 32'd0);
        check("rst_mem_addr", mbus.mem_addr, 32'h0);
        check("rst_if_pc",    if_pc, 32'h0);
        check("rst_if_npc",   if_npc, 32'h0);
        check("rst_if_inst",  if_inst, 32'h0);
        check("rst_if_pred",  if_pred, 32'h0);
        check("rst_stallreq", {31'b0, stallreq_if}, 32'd1);
        check("rst_state",    {30'b0, dbg_state}, {30'b0, IfIdle});

        // sequential fetch of 0, 4, 8 with no stalls
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(32'h4);
        exp_addr_q.push_back(32'h8);
        exp_addr_q.push_back(32'hC);
        exp_pres_q.push_back(pres(32'h0, 32'h4, 32'h4));
        exp_pres_q.push_back(pres(32'h4, 32'h8, 32'h8));
        exp_pres_q.push_back(pres(32'h8, 32'hC, 32'hC));
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_present("present_seq");
            tick();
            check("hold_one_cycle", {31'b0, stallreq_if}, 32'd1);
        end

        // IF/ID stall holds the instruction at 0xC, then rdy=0 freezes it
        stall = 2'b10;
        exp_pres_q.push_back(pres(32'hC, 32'h10, 32'h10));
        exp_addr_q.push_back(32'h10);
        wait_present("present_stall");
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_if_pc",    if_pc, 32'hC);
            check("stall_if_inst",  if_inst, inst_for(32'hC));
            check("stall_stallreq", {31'b0, stallreq_if}, 32'd0);
            check("stall_no_req",   {31'b0, mbus.mem_req}, 32'd0);
        end
        rdy = 1'b0;
        stall = 2'b00;
        repeat (2) begin
            tick();
            check("frozen_stallreq", {31'b0, stallreq_if}, 32'd0);
            check("frozen_if_pc",    if_pc, 32'hC);
        end
        // accept, then PC stall keeps IDLE from requesting
        rdy = 1'b1;
        stall = 2'b01;
        tick();
        check("accept_stallreq", {31'b0, stallreq_if}, 32'd1);
        repeat (4) begin
            tick();
            check("pc_stall_no_req", {31'b0, mbus.mem_req}, 32'd0);
        end
        stall = 2'b00;

        // redirect one cycle after the request for 0x10: read is killed
        exp_pres_q.push_back(pres(32'h100, 32'h104, 32'h104));
        wait_req("req_0x10");
        tick();
        br = 1'b1;
        br_target = 32'h100;
        tick();
        br = 1'b0;
        check("kill_if_pc",    if_pc, 32'h0);
        check("kill_if_inst",  if_inst, 32'h0);
        check("kill_stallreq", {31'b0, stallreq_if}, 32'd1);
        check("kill_state",    {30'b0, dbg_state}, {30'b0, IfWait});
        exp_addr_q.push_back(32'h100);
        wait_present("present_0x100");
        exp_addr_q.push_back(32'h104);
        tick();

        // redirect in the same cycle as mem_done: no kill, straight to IDLE
        wait_done("done_0x104");
        br = 1'b1;
        br_target = 32'h200;
        exp_addr_q.push_back(32'h200);
        exp_pres_q.push_back(pres(32'h200, 32'h204, 32'h204));
        tick();
        br = 1'b0;
        check("brdone_state",    {30'b0, dbg_state}, {30'b0, IfIdle});
        check("brdone_stallreq", {31'b0, stallreq_if}, 32'd1);
        check("brdone_if_pc",    if_pc, 32'h0);
        wait_present("present_0x200");

        // redirect wins over acceptance; target exercises PC wrap
        br = 1'b1;
        br_target = 32'hFFFF_FFFC;
        exp_addr_q.push_back(32'hFFFF_FFFC);
        exp_pres_q.push_back(pres(32'hFFFF_FFFC, 32'h0, 32'h0));
        tick();
        br = 1'b0;
        check("brhold_if_pc",    if_pc, 32'h0);
        check("brhold_stallreq", {31'b0, stallreq_if}, 32'd1);
        wait_present("present_wrap");
        exp_addr_q.push_back(32'h0);
        tick();

        // reset in the middle of WAIT
        wait_req("req_wrap0");
        tick();
        rst = 1'b1;
        tick();
        check("midrst_mem_req",  {31'b0, mbus.mem_req}, 32'd0);
        check("midrst_mem_addr", mbus.mem_addr, 32'h0);
        check("midrst_if_pc",    if_pc, 32'h0);
        check("midrst_if_inst",  if_inst, 32'h0);
        check("midrst_stallreq", {31'b0, stallreq_if}, 32'd1);
        check("midrst_state",    {30'b0, dbg_state}, {30'b0, IfIdle});
        exp_addr_q.push_back(32'h0);
        exp_pres_q.push_back(pres(32'h0, 32'h4, 32'h4));
        rst = 1'b0;
        wait_present("present_after_rst");

`ifdef IF_BTB_EN
        // taken update for 0x10 -> 0x40, then fetch 0x10 via redirect
        upd_en = 1'b1; upd_pc = 32'h10; upd_target = 32'h40; upd_taken = 1'b1;
        br = 1'b1;
        br_target = 32'h10;
        exp_addr_q.push_back(32'h10);
        exp_pres_q.push_back(pres(32'h10, 32'h14, 32'h40));
        tick();
        upd_en = 1'b0;
        br = 1'b0;
        exp_addr_q.push_back(32'h40);
        exp_pres_q.push_back(pres(32'h40, 32'h44, 32'h44));
        wait_present("present_btb_hit");
        tick();
        wait_present("present_0x40");
        // not-taken update invalidates the entry
        upd_en = 1'b1; upd_pc = 32'h10; upd_taken = 1'b0;
        br = 1'b1;
        br_target = 32'h10;
        exp_addr_q.push_back(32'h10);
        exp_pres_q.push_back(pres(32'h10, 32'h14, 32'h14));
        tick();
        upd_en = 1'b0;
        br = 1'b0;
        wait_present("present_btb_miss");
`endif

        // accept the last instruction and keep the PC stalled
        stall = 2'b01;
        tick();
        repeat (10) tick();
        check("drain_mem_req",  {31'b0, mbus.mem_req}, 32'd0);
        check("drain_addr_q",   exp_addr_q.size(), 32'd0);
        check("drain_pres_q",   exp_pres_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction fetch stage: owns the PC, issues 32-bit instruction reads to the memory controller, predicts the next PC, and drives the IF-side inputs of the IF/ID pipeline register (`if_pc`, `if_npc`, `if_inst`, `if_pred`). It obeys the global `stall` bus and the EX-stage branch redirect (`br`, `br_target`). It raises `stallreq_if` whenever no fetched instruction is ready to hand over.

## Interface
Parameters:
- `BTB_IDX_W`, default 4: log2 of the number of BTB entries.
- `BTB_TAG_W`, default 12: BTB tag width, taken from PC bits [17:6].

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `rdy` in 1: global enable. While low, all state freezes.
- `stall` in `StallBus`: global stall vector. Bit 0 = PC, bit 1 = IF/ID.
- `br` in 1: mispredict redirect from EX.
- `br_target` in `InstAddrBus`: correct next PC.
- `upd_en` in 1: BTB update strobe from EX.
- `upd_pc` in `InstAddrBus`: PC of the resolved branch.
- `upd_target` in `InstAddrBus`: target of the resolved branch.
- `upd_taken` in 1: branch was taken.
- `mem_req` out 1: read request.
- `mem_addr` out `InstAddrBus`: read address.
- `mem_done` in 1: one-cycle pulse, `mem_inst` valid.
- `mem_inst` in `InstBus`: assembled instruction word.
- `if_pc`, `if_npc`, `if_pred` out `InstAddrBus`: PC, PC+4, predicted next PC.
- `if_inst` out `InstBus`: instruction.
- `stallreq_if` out 1: fetch not ready.

## Operation
- State machine has three states: IDLE, WAIT, HOLD.
- IDLE, when `!stall[0]`: assert `mem_req`, set `mem_addr=pc`, go to WAIT. `mem_req` stays high until `mem_done`.
- WAIT, on `mem_done` with no kill pending:
  - Register `if_inst=mem_inst`, `if_pc=pc`, `if_npc=pc+4`, `if_pred=pred(pc)`.
  - Go to HOLD.
- HOLD: the instruction is handed over at the first edge with `rdy && !stall[1] && !br`. At that edge, `pc<=if_pred` and the state goes to IDLE. Otherwise the outputs are held.
- `stallreq_if` = (state != HOLD).
- Redirect: `br` in any state sets `pc<=br_target` and clears the `if_*` outputs to 0.
  - In IDLE or HOLD: next state is IDLE.
  - In WAIT: set `kill`, because the memory read cannot be aborted. The matching `mem_done` is discarded, `kill` clears, and the state goes to IDLE.
- `br` has priority over `stall`.
- PC arithmetic is 32-bit wrapping. `0xFFFFFFFC+4=0`.

## Timing
- Reset values: `pc=0`, state IDLE, `kill=0`, `mem_req=0`, `mem_addr=0`, all `if_*=0`, `stallreq_if=1`, all BTB valid bits cleared.
- `mem_req` rises one cycle after entering IDLE with `!stall[0]`.
- `mem_done` at cycle N gives `if_*` valid and `stallreq_if=0` from cycle N+1.
- The earliest next request after acceptance at edge M is `mem_req` in cycle M+1.
- `br` and `mem_done` in the same cycle: the instruction is discarded, `pc=br_target`, state goes to IDLE, and `kill` is not set.
- `br` and acceptance in the same cycle: `br` wins, and `pc` is not advanced to `if_pred`.
- `rst` in WAIT: state goes to IDLE. The memory controller is reset by the same `rst`, so no stale `mem_done` arrives.
- `rdy=0` in the same cycle as `mem_done`: the memory controller holds `mem_done` until `rdy`, so no instruction is lost.

## Configuration
- `IF_BTB_EN` defined:
  - Direct-mapped BTB with `2^BTB_IDX_W` entries, indexed by `pc[5:2]`.
  - On a valid tag hit, `pred(pc)=target`. Otherwise `pred(pc)=pc+4`.
  - Write on `upd_en&&upd_taken` (set valid, tag, target).
  - Invalidate on `upd_en&&!upd_taken` if the tag matches.
  - Lookup is combinational on `pc`. An update in the same cycle as a lookup is not visible to that lookup.
- `IF_BTB_EN` undefined: `if_pred=pc+4`, `upd_*` are ignored, no BTB storage.

## Structure
- `defines.v`: `InstAddrBus`, `InstBus`, `StallBus`, `ZeroWord`, IF state encodings (`IfIdle`, `IfWait`, `IfHold`), BTB size constants.
- Sub-module `if_btb`: storage, lookup and update. Instantiated only under `IF_BTB_EN`.

## Test plan
- Reset, then `mem_done` after 3 cycles each with `mem_inst=0x00000013`, no stalls → PCs 0, 4, 8 are presented. `if_npc=if_pc+4`. `stallreq_if` is low exactly one cycle per instruction.
- `stall[1]=1` for 5 cycles while in HOLD → `if_*` are unchanged, no `mem_req`. Resume → `pc` advances to 4.
- `br=1`, `br_target=0x100` one cycle after `mem_req` for PC 8 → the returned instruction is dropped, the next `mem_addr=0x100`, and `if_pc=0x100` with the `mem_inst` returned for that request.
- `br` in the same cycle as `mem_done` → the instruction is not presented, the next `mem_addr=br_target`.
- With `IF_BTB_EN`: update with `upd_pc=0x10`, `upd_target=0x40`, taken. Next fetch of 0x10 → `if_pred=0x40` and the next `mem_addr=0x40`. Update not-taken → `if_pred=0x14`.
- `rst` asserted mid-WAIT → the next cycle shows the reset values, and `mem_addr=0` is requested after `rst` deasserts.
